sr_latch_driver: RTL and testbench

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_latch_driver.sv | 138 +++++++++++++
 tb/tb_sr_latch_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// ----------------------------------------------------------------------------
// sr_latch_driver
//
// Drives an external set/reset latch with a timed, non-overlapping S or R
// pulse, waits a guard gap, then reads back the latch Q/notQ pins to confirm
// the new value.
//
// Parameters
//   PULSE_W  S/R pulse width in clock cycles (1..15)
//   GAP_W    guard cycles after the pulse with S=R=0 (0..15)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req_valid  in   a latch command is offered
//   req_op     in   command: 1 = set (drive S), 0 = clear (drive R)
//   req_ready  out  block can accept a command this cycle
//   S, R       out  set / reset drives to the external latch
//   Q_fb       in   latch Q feedback
//   notQ_fb    in   latch notQ feedback
//   done       out  one-cycle pulse when a command completes
//   err        out  one-cycle pulse with done when readback fails
//   q_state    out  last confirmed latch value
// ----------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q_fb,
    input  logic notQ_fb,
    output logic done,
    output logic err,
    output logic q_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    // Counter holds "cycles remaining minus one" in the current timed state.
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LOAD   = (GAP_W > 0) ? 4'(GAP_W - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       op_q, op_d;
    logic       q_state_q, q_state_d;
    logic       check_fail;

    // Readback is only looked at while in CHECK; a healthy latch shows Q equal
    // to the commanded value and complementary notQ.
    assign check_fail = (state_q == ST_CHECK) &&
                        ((Q_fb != op_q) || (notQ_fb == Q_fb));

    // Outputs decoded from registered state. S and R both depend on being in
    // PULSE and on opposite polarities of op_q, so they can never overlap.
    // req_ready is additionally masked by reset so no command is offered
    // acceptance while reset is being applied.
    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign S         = (state_q == ST_PULSE) &&  op_q;
    assign R         = (state_q == ST_PULSE) && !op_q;
    assign done      = (state_q == ST_CHECK);
    assign err       = check_fail;
    assign q_state   = q_state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        q_state_d = q_state_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    cnt_d   = PULSE_LOAD;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    if (GAP_W > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_CHECK;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                // Only a confirmed readback updates the reported latch value.
                if (!check_fail) begin
                    q_state_d = op_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_q      <= 1'b0;
            q_state_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            q_state_q <= q_state_d;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// ----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Directed bench for sr_latch_driver. Two instances: one with default
// parameters (PULSE_W=2, GAP_W=1) and one at minimum timing (PULSE_W=1,
// GAP_W=0). Each drives a behavioural SR latch model whose feedback pins can
// be forced into fault conditions. Inputs change 1 time unit after the rising
// edge and outputs are checked there as well.
// ----------------------------------------------------------------------------
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic reset;

    // default-parameter instance
    logic req_valid, req_op, req_ready, S, R, Q_fb, notQ_fb, done, err, q_state;
    // minimum-timing instance
    logic m_valid, m_op, m_ready, m_S, m_R, m_Q_fb, m_notQ_fb, m_done, m_err, m_q_state;

    // latch models and fault controls
    logic q_m   = 1'b0;
    logic m_q_m = 1'b0;
    logic fault_stuck0 = 1'b0;  // Q pin stuck low
    logic fault_both0  = 1'b0;  // Q and notQ both low

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_latch_driver dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .Q_fb      (Q_fb),
        .notQ_fb   (notQ_fb),
        .done      (done),
        .err       (err),
        .q_state   (q_state)
    );

    sr_latch_driver #(.PULSE_W(1), .GAP_W(0)) dut_min (
        .clk       (clk),
        .reset     (reset),
        .req_valid (m_valid),
        .req_op    (m_op),
        .req_ready (m_ready),
        .S         (m_S),
        .R         (m_R),
        .Q_fb      (m_Q_fb),
        .notQ_fb   (m_notQ_fb),
        .done      (m_done),
        .err       (m_err),
        .q_state   (m_q_state)
    );

    // Behavioural SR latches: S wins if both were ever driven.
    always @(posedge clk) begin
        if (S)      q_m <= 1'b1;
        else if (R) q_m <= 1'b0;
        if (m_S)      m_q_m <= 1'b1;
        else if (m_R) m_q_m <= 1'b0;
    end

    assign Q_fb      = (fault_stuck0 || fault_both0) ? 1'b0 : q_m;
    assign notQ_fb   = fault_both0 ? 1'b0 : ~q_m;
    assign m_Q_fb    = m_q_m;
    assign m_notQ_fb = ~m_q_m;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One complete command on the default instance (PULSE_W=2, GAP_W=1).
    task automatic run_cmd(input string tag, input logic op, input logic exp_err,
                           input logic q_before, input logic q_after);
        req_valid = 1'b1;
        req_op    = op;
        tick();
        req_valid = 1'b0;
        for (int p = 0; p < 2; p++) begin
            chk({tag, " pulse S"}, S, op);
            chk({tag, " pulse R"}, R, !op);
            chk({tag, " pulse ready"}, req_ready, 1'b0);
            chk({tag, " pulse done"}, done, 1'b0);
            tick();
        end
        chk({tag, " gap S"}, S, 1'b0);
        chk({tag, " gap R"}, R, 1'b0);
        chk({tag, " gap done"}, done, 1'b0);
        tick();
        chk({tag, " check done"}, done, 1'b1);
        chk({tag, " check err"}, err, exp_err);
        chk({tag, " check S"}, S, 1'b0);
        chk({tag, " check R"}, R, 1'b0);
        chk({tag, " check q_state"}, q_state, q_before);
        chk({tag, " check ready"}, req_ready, 1'b0);
        tick();
        chk({tag, " idle q_state"}, q_state, q_after);
        chk({tag, " idle ready"}, req_ready, 1'b1);
        chk({tag, " idle done"}, done, 1'b0);
        chk({tag, " idle err"}, err, 1'b0);
    endtask

    initial begin
        logic op;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        m_valid   = 1'b0;
        m_op      = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst ready", req_ready, 1'b0);
        chk("rst S", S, 1'b0);
        chk("rst R", R, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst q_state", q_state, 1'b0);
        chk("rst m_ready", m_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("rel ready", req_ready, 1'b1);
        chk("rel m_ready", m_ready, 1'b1);

        // ---------------- set then clear ----------------
        run_cmd("set", 1'b1, 1'b0, 1'b0, 1'b1);
        run_cmd("clear", 1'b0, 1'b0, 1'b1, 1'b0);

        // ---------------- busy: valid held, op changed while busy ----------
        req_valid = 1'b1;
        req_op    = 1'b1;
        tick();
        req_op = 1'b0;  // must be ignored until IDLE
        chk("busy p1 S", S, 1'b1);
        chk("busy p1 R", R, 1'b0);
        tick();
        chk("busy p2 S", S, 1'b1);
        chk("busy p2 R", R, 1'b0);
        tick();
        chk("busy gap S", S, 1'b0);
        chk("busy gap R", R, 1'b0);
        tick();
        chk("busy check done", done, 1'b1);
        chk("busy check S", S, 1'b0);
        tick();
        chk("busy idle ready", req_ready, 1'b1);
        chk("busy idle q_state", q_state, 1'b1);
        chk("busy idle S", S, 1'b0);
        chk("busy idle R", R, 1'b0);
        tick();  // second command (clear) accepted with no bubble
        req_valid = 1'b0;
        chk("b2b p1 R", R, 1'b1);
        chk("b2b p1 S", S, 1'b0);
        tick();
        chk("b2b p2 R", R, 1'b1);
        tick();
        chk("b2b gap R", R, 1'b0);
        tick();
        chk("b2b check done", done, 1'b1);
        chk("b2b check err", err, 1'b0);
        tick();
        chk("b2b idle q_state", q_state, 1'b0);

        // ---------------- faulty latch ----------------
        fault_stuck0 = 1'b1;
        run_cmd("stuck0 set", 1'b1, 1'b1, 1'b0, 1'b0);
        fault_stuck0 = 1'b0;
        run_cmd("good set", 1'b1, 1'b0, 1'b0, 1'b1);
        fault_both0 = 1'b1;
        run_cmd("both0 clear", 1'b0, 1'b1, 1'b1, 1'b1);
        fault_both0 = 1'b0;

        // ---------------- repeated same-value command ----------------
        run_cmd("set again", 1'b1, 1'b0, 1'b1, 1'b1);
        run_cmd("set repeat", 1'b1, 1'b0, 1'b1, 1'b1);

        // ---------------- reset mid-pulse ----------------
        req_valid = 1'b1;
        req_op    = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("rmid p1 R", R, 1'b1);
        tick();
        chk("rmid p2 R", R, 1'b1);
        reset = 1'b1;
        tick();
        chk("rmid S", S, 1'b0);
        chk("rmid R", R, 1'b0);
        chk("rmid ready", req_ready, 1'b0);
        chk("rmid q_state", q_state, 1'b0);
        chk("rmid done", done, 1'b0);
        reset = 1'b0;
        #1;
        chk("rmid rel ready", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rmid no done", done, 1'b0);
            chk("rmid no err", err, 1'b0);
            chk("rmid no R", R, 1'b0);
        end

        // ---------------- minimum timing, random commands ----------------
        for (int i = 0; i < 100; i++) begin
            op      = 1'($urandom_range(0, 1));
            m_valid = 1'b1;
            m_op    = op;
            tick();
            m_valid = 1'b0;
            chk("min pulse S", m_S, op);
            chk("min pulse R", m_R, !op);
            chk("min S&R", m_S & m_R, 1'b0);
            tick();
            chk("min done", m_done, 1'b1);
            chk("min err", m_err, 1'b0);
            chk("min check S&R", m_S | m_R, 1'b0);
            tick();
            chk("min q_state", m_q_state, op);
            chk("min ready", m_ready, 1'b1);
            chk("min idle done", m_done, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
